// File: rtl/axis_frame_gen_pkg.sv
// Shared types and constants for the AXI-Stream frame generator.
//   state_t   : run-control FSM states (IDLE, SEND, GAP)
//   CNT_WIDTH : width of the frame index and of the status counters
//   CNT_MAX   : saturation value of the status counters
package axis_frame_gen_pkg;

  localparam int CNT_WIDTH = 16;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/axis_frame_gen_sat_cnt.sv
// Saturating up-counter used for the frames_sent and drops_seen status.
//   clk, rst : clock, synchronous active-high reset
//   clr      : synchronous clear, wins over inc
//   inc      : increment by one unless already at CNT_MAX
//   count    : current value
module axis_frame_gen_sat_cnt
  import axis_frame_gen_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  // NOTE: clocked state is written with non-blocking assignments so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/axis_frame_gen.sv
// AXI-Stream frame transmitter for bench / bring-up / board loopback.
// Emits cfg_frames frames (0 = until stop) of cfg_len beats (0 treated as 1)
// separated by cfg_gap idle cycles; every cfg_bad_every-th frame carries
// tuser on its last beat. Beat b of frame k carries (k + b) mod 2^DATA_WIDTH.
// Counts completed frames and rising edges of the FIFO's drop_frame.
//   clk, rst            : clock, synchronous active-high reset
//   start, stop         : one-cycle run control pulses
//   cfg_*               : run configuration, latched on an accepted start
//   output_axis_*       : AXI-Stream master (all outputs registered)
//   drop_frame          : drop indication from the downstream FIFO
//   busy                : run in progress
//   frames_sent         : frames completed in current/last run (saturating)
//   drops_seen          : drop_frame rising edges since last start (saturating)
module axis_frame_gen
  import axis_frame_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int GAP_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  stop,
  input  logic [CNT_WIDTH-1:0]  cfg_frames,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [GAP_WIDTH-1:0]  cfg_gap,
  input  logic [7:0]            cfg_bad_every,
  output logic [DATA_WIDTH-1:0] output_axis_tdata,
  output logic                  output_axis_tvalid,
  input  logic                  output_axis_tready,
  output logic                  output_axis_tlast,
  output logic                  output_axis_tuser,
  input  logic                  drop_frame,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  frames_sent,
  output logic [CNT_WIDTH-1:0]  drops_seen
);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                  tvalid_q, tvalid_d;
  logic                  tlast_q, tlast_d;
  logic                  tuser_q, tuser_d;
  logic [LEN_WIDTH-1:0]  beat_q, beat_d;
  // One register serves as both frame index (data seed) and frame count
  // (run-length compare); both are cleared on start and step together.
  logic [CNT_WIDTH-1:0]  frame_q, frame_d;
  logic [GAP_WIDTH-1:0]  gap_q, gap_d;
  // Frames remaining until the next bad frame; 1 means the current frame.
  logic [7:0]            bad_q, bad_d;
  logic                  stop_pend_q, stop_pend_d;

  logic [CNT_WIDTH-1:0]  cfg_frames_q, cfg_frames_d;
  logic [LEN_WIDTH-1:0]  last_beat_q, last_beat_d;
  logic [GAP_WIDTH-1:0]  cfg_gap_q, cfg_gap_d;
  logic [7:0]            cfg_bad_q, cfg_bad_d;

  logic                  drop_q;
  logic                  start_acc;
  logic                  sent_inc;

  logic                  hs;
  logic [CNT_WIDTH-1:0]  frame_nxt;
  logic [LEN_WIDTH-1:0]  beat_inc;
  logic [7:0]            bad_nxt;
  logic                  run_end;

  assign hs        = tvalid_q & output_axis_tready;
  assign frame_nxt = frame_q + 1'b1;
  assign beat_inc  = beat_q + 1'b1;
  assign bad_nxt   = (bad_q <= 8'd1) ? cfg_bad_q : bad_q - 8'd1;
  assign run_end   = stop_pend_q | stop |
                     ((cfg_frames_q != '0) && (frame_nxt == cfg_frames_q));

  // NOTE: every signal driven here gets its default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    tdata_d      = tdata_q;
    tvalid_d     = tvalid_q;
    tlast_d      = tlast_q;
    tuser_d      = tuser_q;
    beat_d       = beat_q;
    frame_d      = frame_q;
    gap_d        = gap_q;
    bad_d        = bad_q;
    stop_pend_d  = stop_pend_q;
    cfg_frames_d = cfg_frames_q;
    last_beat_d  = last_beat_q;
    cfg_gap_d    = cfg_gap_q;
    cfg_bad_d    = cfg_bad_q;
    start_acc    = 1'b0;
    sent_inc     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          start_acc    = 1'b1;
          cfg_frames_d = cfg_frames;
          last_beat_d  = (cfg_len == '0) ? '0 : cfg_len - 1'b1;
          cfg_gap_d    = cfg_gap;
          cfg_bad_d    = cfg_bad_every;
          bad_d        = cfg_bad_every;
          frame_d      = '0;
          beat_d       = '0;
          stop_pend_d  = 1'b0;
          state_d      = SEND;
          tvalid_d     = 1'b1;
          tdata_d      = '0;
          tlast_d      = (cfg_len <= LEN_WIDTH'(1));
          tuser_d      = (cfg_len <= LEN_WIDTH'(1)) && (cfg_bad_every == 8'd1);
        end
      end

      SEND: begin
        if (stop) stop_pend_d = 1'b1;
        if (hs) begin
          if (tlast_q) begin
            sent_inc = 1'b1;
            frame_d  = frame_nxt;
            bad_d    = bad_nxt;
            beat_d   = '0;
            if (run_end) begin
              state_d  = IDLE;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              tuser_d  = 1'b0;
            end else if (cfg_gap_q == '0) begin
              // Back-to-back: beat 0 of the next frame follows immediately.
              tdata_d = DATA_WIDTH'(frame_nxt);
              tlast_d = (last_beat_q == '0);
              tuser_d = (last_beat_q == '0) && (bad_nxt == 8'd1);
            end else begin
              state_d  = GAP;
              gap_d    = cfg_gap_q;
              tvalid_d = 1'b0;
              tlast_d  = 1'b0;
              tuser_d  = 1'b0;
            end
          end else begin
            beat_d  = beat_inc;
            tdata_d = tdata_q + 1'b1;
            tlast_d = (beat_inc == last_beat_q);
            tuser_d = (beat_inc == last_beat_q) && (bad_q == 8'd1);
          end
        end
      end

      GAP: begin
        if (stop || stop_pend_q) begin
          state_d = IDLE;
        end else if (gap_q == GAP_WIDTH'(1)) begin
          state_d  = SEND;
          tvalid_d = 1'b1;
          tdata_d  = DATA_WIDTH'(frame_q);
          tlast_d  = (last_beat_q == '0);
          tuser_d  = (last_beat_q == '0) && (bad_q == 8'd1);
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end

      default: begin
        state_d  = IDLE;
        tvalid_d = 1'b0;
        tlast_d  = 1'b0;
        tuser_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      tlast_q      <= 1'b0;
      tuser_q      <= 1'b0;
      beat_q       <= '0;
      frame_q      <= '0;
      gap_q        <= '0;
      bad_q        <= '0;
      stop_pend_q  <= 1'b0;
      cfg_frames_q <= '0;
      last_beat_q  <= '0;
      cfg_gap_q    <= '0;
      cfg_bad_q    <= '0;
      drop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      tlast_q      <= tlast_d;
      tuser_q      <= tuser_d;
      beat_q       <= beat_d;
      frame_q      <= frame_d;
      gap_q        <= gap_d;
      bad_q        <= bad_d;
      stop_pend_q  <= stop_pend_d;
      cfg_frames_q <= cfg_frames_d;
      last_beat_q  <= last_beat_d;
      cfg_gap_q    <= cfg_gap_d;
      cfg_bad_q    <= cfg_bad_d;
      drop_q       <= drop_frame;
    end
  end

  axis_frame_gen_sat_cnt u_frames_sent (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc),
    .inc   (sent_inc),
    .count (frames_sent)
  );

  // The edge detector keeps running across start so an already-high
  // drop_frame is not recounted as a new episode.
  axis_frame_gen_sat_cnt u_drops_seen (
    .clk   (clk),
    .rst   (rst),
    .clr   (start_acc),
    .inc   (drop_frame & ~drop_q),
    .count (drops_seen)
  );

  assign output_axis_tdata  = tdata_q;
  assign output_axis_tvalid = tvalid_q;
  assign output_axis_tlast  = tlast_q;
  assign output_axis_tuser  = tuser_q;
  assign busy               = (state_q != IDLE);

endmodule

// File: tb/tb_axis_frame_gen.sv
// Self-checking bench for axis_frame_gen. A cycle monitor on the falling
// edge compares the DUT against a frame-level model (frame/beat numbers,
// modulo arithmetic for data and bad-frame cadence); directed scenarios add
// literal expectations on the captured beat log.
module tb_axis_frame_gen;

  localparam int DW = 8;
  localparam int LW = 8;
  localparam int GW = 4;

  logic          clk;
  logic          rst;
  logic          start;
  logic          stop;
  logic [15:0]   cfg_frames;
  logic [LW-1:0] cfg_len;
  logic [GW-1:0] cfg_gap;
  logic [7:0]    cfg_bad_every;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tready;
  logic          tlast;
  logic          tuser;
  logic          drop_frame;
  logic          busy;
  logic [15:0]   frames_sent;
  logic [15:0]   drops_seen;

  axis_frame_gen #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .GAP_WIDTH  (GW)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .start              (start),
    .stop               (stop),
    .cfg_frames         (cfg_frames),
    .cfg_len            (cfg_len),
    .cfg_gap            (cfg_gap),
    .cfg_bad_every      (cfg_bad_every),
    .output_axis_tdata  (tdata),
    .output_axis_tvalid (tvalid),
    .output_axis_tready (tready),
    .output_axis_tlast  (tlast),
    .output_axis_tuser  (tuser),
    .drop_frame         (drop_frame),
    .busy               (busy),
    .frames_sent        (frames_sent),
    .drops_seen         (drops_seen)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic          user;
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t log_q[$];

  // ---------------- behavioural model state ----------------
  bit    m_run, m_stop_pend, m_after_last, m_stall, m_drop_prev;
  int    m_frame, m_beat, m_done, m_drops, m_gap_cnt, m_gap_total;
  int    m_frames, m_last, m_gap, m_bad;
  beat_t m_hold;

  always @(negedge clk) begin
    bit    was_running;
    beat_t cur, exp_b;
    cur = '{user: tuser, last: tlast, data: tdata};
    if (rst) begin
      m_run = 0; m_done = 0; m_drops = 0; m_drop_prev = 0; m_stall = 0;
    end else begin
      check("frames_sent", 32'(frames_sent), 32'(m_done));
      check("drops_seen", 32'(drops_seen), 32'(m_drops));
      was_running = m_run;
      if (m_run) begin
        check("busy_in_run", 32'(busy), 1);
        if (stop) m_stop_pend = 1;
        if (tvalid) begin
          if (m_stall) check("held_beat", 32'(cur), 32'(m_hold));
          if (m_after_last) begin
            check("gap_length", m_gap_cnt, m_gap);
            m_after_last = 0;
          end
          if (tready) begin
            exp_b.data = DW'((m_frame + m_beat) % 256);
            exp_b.last = (m_beat == m_last);
            exp_b.user = exp_b.last && (m_bad != 0) && (((m_frame + 1) % m_bad) == 0);
            check("beat", 32'(cur), 32'(exp_b));
            log_q.push_back(cur);
            m_stall = 0;
            if (exp_b.last) begin
              m_done++; m_frame++; m_beat = 0;
              if (m_stop_pend || (m_frames != 0 && m_done == m_frames)) m_run = 0;
              else begin m_after_last = 1; m_gap_cnt = 0; end
            end else begin
              m_beat++;
            end
          end else begin
            m_stall = 1;
            m_hold  = cur;
          end
        end else begin
          if (!m_after_last) check("tvalid_held_in_frame", 32'(tvalid), 1);
          else begin
            m_gap_cnt++; m_gap_total++;
            if (stop) m_run = 0;
          end
        end
      end else begin
        check("idle_busy", 32'(busy), 0);
        check("idle_tvalid", 32'(tvalid), 0);
      end
      if (!was_running && start) begin
        m_run = 1; m_frame = 0; m_beat = 0; m_done = 0; m_stall = 0;
        m_after_last = 0; m_stop_pend = 0;
        m_frames = int'(cfg_frames);
        m_last   = (cfg_len == 0) ? 0 : int'(cfg_len) - 1;
        m_gap    = int'(cfg_gap);
        m_bad    = int'(cfg_bad_every);
        m_drops  = 0;
      end else if (drop_frame && !m_drop_prev && m_drops != 16'hFFFF) begin
        m_drops++;
      end
      m_drop_prev = drop_frame;
    end
  end

  // ---------------- background stimulus ----------------
  bit rand_ready = 0;
  bit drop_rand  = 0;

  always @(posedge clk) begin
    #1;
    if (rand_ready) tready = 1'($urandom % 2);
    if (drop_rand) drop_frame = ($urandom % 4 == 0);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- helpers ----------------
  task automatic set_cfg(input int frames, input int len, input int gap, input int bad);
    cfg_frames    = 16'(frames);
    cfg_len       = LW'(len);
    cfg_gap       = GW'(gap);
    cfg_bad_every = 8'(bad);
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_stop();
    @(posedge clk); #1 stop = 1'b1;
    @(posedge clk); #1 stop = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (!busy) break;
    end
    check("idle_within_budget", 32'(busy), 0);
  endtask

  task automatic wait_log(input int cnt, input int budget);
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if (log_q.size() >= cnt) break;
    end
    check("log_reached", 32'(log_q.size() >= cnt), 1);
  endtask

  task automatic fixed_ready();
    rand_ready = 0;
    @(posedge clk); #2 tready = 1'b1;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    int exp1 [8];
    rst = 1'b1; start = 1'b0; stop = 1'b0; tready = 1'b1; drop_frame = 1'b0;
    set_cfg(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_tvalid", 32'(tvalid), 0);
    check("rst_tlast", 32'(tlast), 0);
    check("rst_tuser", 32'(tuser), 0);
    check("rst_tdata", 32'(tdata), 0);
    check("rst_busy", 32'(busy), 0);

    // 1: two back-to-back 4-beat frames
    exp1 = '{0, 1, 2, 3, 1, 2, 3, 4};
    log_q.delete();
    set_cfg(2, 4, 0, 0);
    pulse_start();
    wait_idle(100);
    check("t1_beats", log_q.size(), 8);
    for (int i = 0; i < 8 && i < log_q.size(); i++) begin
      check("t1_data", 32'(log_q[i].data), exp1[i]);
      check("t1_last", 32'(log_q[i].last), 32'(i == 3 || i == 7));
    end
    check("t1_frames_sent", 32'(frames_sent), 2);

    // 2: gap of two idle cycles between three 3-beat frames
    log_q.delete(); m_gap_total = 0;
    set_cfg(3, 3, 2, 0);
    pulse_start();
    wait_idle(100);
    check("t2_beats", log_q.size(), 9);
    check("t2_gap_cycles", m_gap_total, 4);
    check("t2_frames_sent", 32'(frames_sent), 3);

    // 3: every third frame flagged bad
    log_q.delete();
    set_cfg(6, 2, 0, 3);
    pulse_start();
    wait_idle(100);
    check("t3_beats", log_q.size(), 12);
    for (int i = 0; i < 12 && i < log_q.size(); i++)
      check("t3_tuser", 32'(log_q[i].user), 32'(i == 5 || i == 11));

    // 4: random backpressure, stop in the middle of the second frame
    log_q.delete();
    set_cfg(0, 5, 1, 0);
    rand_ready = 1;
    pulse_start();
    wait_log(7, 500);
    pulse_stop();
    wait_idle(500);
    fixed_ready();
    check("t4_frames_sent", 32'(frames_sent), 2);
    check("t4_beats", log_q.size(), 10);

    // 5: continuous single-beat frames, two drop episodes, then stop
    log_q.delete();
    set_cfg(0, 0, 0, 0);
    pulse_start();
    repeat (4) @(posedge clk);
    for (int p = 0; p < 2; p++) begin
      @(posedge clk); #1 drop_frame = 1'b1;
      repeat (3) @(posedge clk);
      #1 drop_frame = 1'b0;
      repeat (3) @(posedge clk);
    end
    pulse_stop();
    wait_idle(50);
    check("t5_drops_seen", 32'(drops_seen), 2);
    check("t5_some_beats", 32'(log_q.size() > 10), 1);
    for (int i = 0; i < log_q.size(); i++) begin
      check("t5_tlast", 32'(log_q[i].last), 1);
      check("t5_data", 32'(log_q[i].data), 32'(i % 256));
    end

    // 6: reset during beat 2 of a 6-beat frame
    log_q.delete();
    set_cfg(0, 6, 0, 0);
    pulse_start();
    wait_log(2, 50);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("t6_tvalid", 32'(tvalid), 0);
    check("t6_busy", 32'(busy), 0);
    check("t6_frames_sent", 32'(frames_sent), 0);
    log_q.delete();
    set_cfg(1, 6, 0, 0);
    pulse_start();
    wait_idle(50);
    check("t6_beats", log_q.size(), 6);
    if (log_q.size() > 0) check("t6_first_data", 32'(log_q[0].data), 0);

    // 7: randomized runs with config churn, stray starts, stops, drops
    for (int r = 0; r < 12; r++) begin
      bit do_stop;
      int stop_at;
      set_cfg(1 + $urandom % 5, $urandom % 8, $urandom % 4, $urandom % 5);
      do_stop = ($urandom % 3 == 0);
      stop_at = $urandom_range(2, 30);
      rand_ready = 1; drop_rand = 1;
      pulse_start();
      for (int cyc = 0; cyc < 2000; cyc++) begin
        @(posedge clk); #1;
        start = ($urandom % 16 == 0);
        stop  = do_stop && (cyc == stop_at);
        if ($urandom % 8 == 0)
          set_cfg(1 + $urandom % 5, $urandom % 8, $urandom % 4, $urandom % 5);
        @(negedge clk);
        if (!busy) break;
      end
      @(posedge clk); #1 start = 1'b0; stop = 1'b0;
      wait_idle(2000);
      drop_rand = 0;
      fixed_ready();
      drop_frame = 1'b0;
      repeat (2) @(posedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
